// File: rtl/dram_dma_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dram_dma_ctrl
//
// Memory test engine for an AXI HP port. A run writes num_beats_i beats to
// DRAM starting at base_addr_i, then reads them back and compares each beat.
// Every beat carries its own byte address as data, zero-extended (or
// truncated) to DATA_W. Transfers are INCR bursts of at most BURST_LEN beats,
// and only one AXI transaction is outstanding at any time.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   start_i                 one-cycle run request, accepted only when idle
//   base_addr_i             first byte address, aligned to a full burst
//   num_beats_i             beats to write and read back (0 = empty run)
//   done_o                  one-cycle pulse at the end of a run
//   err_cnt_o               saturating count of bad beats / error responses
//   aw* / w* / b*           AXI write address, data and response channels
//   ar* / r*                AXI read address and data channels
// AxSIZE, AxBURST, WSTRB and the IDs are tied off by the instantiating top.
// ---------------------------------------------------------------------------
module dram_dma_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [15:0]       num_beats_i,
    output logic              done_o,
    output logic [15:0]       err_cnt_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rlast_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [1:0]        rresp_i
);

    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;       // run base, reused as the first read address
    logic [15:0]       total_q;      // run length, reloaded for the read pass
    logic [15:0]       remain_q;     // beats of this pass not yet finished, current burst included
    logic [8:0]        cur_len_q;    // beats in the burst in flight
    logic [8:0]        beat_idx_q;   // write beat position inside the burst
    logic [ADDR_W-1:0] beat_addr_q;  // byte address of the next data beat (write or read)

    // Beats in the next burst: a full burst, or whatever is left.
    function automatic logic [8:0] burst_len(input logic [15:0] rem);
        if (rem >= 16'(BURST_LEN)) begin
            return 9'(BURST_LEN);
        end
        return rem[8:0];
    endfunction

    // Expected data of a beat: its byte address, zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] addr);
        logic [DATA_W+ADDR_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, addr};
        return wide[DATA_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] beats_to_bytes(input logic [8:0] beats);
        return ADDR_W'(beats) << BYTE_SHIFT;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic [8:0]        start_len;
    logic [8:0]        total_len;
    logic [15:0]       remain_after;
    logic [8:0]        next_len;
    logic [ADDR_W-1:0] beat_addr_inc;
    logic              rd_beat_bad;
    logic              wr_last_next;

    assign start_len     = burst_len(num_beats_i);
    assign total_len     = burst_len(total_q);
    assign remain_after  = remain_q - 16'(cur_len_q);
    assign next_len      = burst_len(remain_after);
    assign beat_addr_inc = beat_addr_q + beats_to_bytes(9'd1);
    // A beat that is both corrupted and flagged by rresp counts once.
    assign rd_beat_bad   = (rdata_i != addr_pattern(beat_addr_q)) || (rresp_i != 2'b00);
    // The beat after the one being accepted is the burst's final beat.
    assign wr_last_next  = ((beat_idx_q + 9'd2) == cur_len_q);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            base_q      <= '0;
            total_q     <= '0;
            remain_q    <= '0;
            cur_len_q   <= '0;
            beat_idx_q  <= '0;
            beat_addr_q <= '0;
            done_o      <= 1'b0;
            err_cnt_o   <= '0;
            awaddr_o    <= '0;
            awlen_o     <= '0;
            awvalid_o   <= 1'b0;
            wdata_o     <= '0;
            wlast_o     <= 1'b0;
            wvalid_o    <= 1'b0;
            bready_o    <= 1'b0;
            araddr_o    <= '0;
            arlen_o     <= '0;
            arvalid_o   <= 1'b0;
            rready_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        base_q    <= base_addr_i;
                        total_q   <= num_beats_i;
                        err_cnt_o <= '0;
                        if (num_beats_i == 16'd0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= WR_ADDR;
                            awaddr_o    <= base_addr_i;
                            awlen_o     <= 8'(start_len - 9'd1);
                            awvalid_o   <= 1'b1;
                            remain_q    <= num_beats_i;
                            cur_len_q   <= start_len;
                            beat_addr_q <= base_addr_i;
                        end
                    end
                end

                WR_ADDR: begin
                    if (awready_i) begin
                        awvalid_o  <= 1'b0;
                        wvalid_o   <= 1'b1;
                        wdata_o    <= addr_pattern(beat_addr_q);
                        wlast_o    <= (cur_len_q == 9'd1);
                        beat_idx_q <= '0;
                        state      <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (wready_i) begin
                        beat_addr_q <= beat_addr_inc;
                        if (wlast_o) begin
                            wvalid_o <= 1'b0;
                            wlast_o  <= 1'b0;
                            bready_o <= 1'b1;
                            state    <= WR_RESP;
                        end else begin
                            wdata_o    <= addr_pattern(beat_addr_inc);
                            wlast_o    <= wr_last_next;
                            beat_idx_q <= beat_idx_q + 9'd1;
                        end
                    end
                end

                WR_RESP: begin
                    if (bvalid_i) begin
                        bready_o <= 1'b0;
                        if (bresp_i != 2'b00) begin
                            err_cnt_o <= sat_inc(err_cnt_o);
                        end
                        if (remain_after == 16'd0) begin
                            // Write pass complete: restart from the base for readback.
                            state       <= RD_ADDR;
                            araddr_o    <= base_q;
                            arlen_o     <= 8'(total_len - 9'd1);
                            arvalid_o   <= 1'b1;
                            remain_q    <= total_q;
                            cur_len_q   <= total_len;
                            beat_addr_q <= base_q;
                        end else begin
                            state     <= WR_ADDR;
                            awaddr_o  <= awaddr_o + beats_to_bytes(cur_len_q);
                            awlen_o   <= 8'(next_len - 9'd1);
                            awvalid_o <= 1'b1;
                            remain_q  <= remain_after;
                            cur_len_q <= next_len;
                        end
                    end
                end

                RD_ADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid_i) begin
                        beat_addr_q <= beat_addr_inc;
                        if (rd_beat_bad) begin
                            err_cnt_o <= sat_inc(err_cnt_o);
                        end
                        // The slave's rlast, not a local count, closes the burst.
                        if (rlast_i) begin
                            rready_o <= 1'b0;
                            if (remain_after == 16'd0) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state     <= RD_ADDR;
                                araddr_o  <= araddr_o + beats_to_bytes(cur_len_q);
                                arlen_o   <= 8'(next_len - 9'd1);
                                arvalid_o <= 1'b1;
                                remain_q  <= remain_after;
                                cur_len_q <= next_len;
                            end
                        end
                    end
                end

                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_dma_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dram_dma_ctrl
//
// Bench for dram_dma_ctrl. A behavioural AXI slave (memory plus randomised
// ready/valid stalls and injectable faults) answers the controller. For each
// run the bench derives, from burst arithmetic, the bursts and beats that
// must appear on the bus and the error count that must be reported; a
// monitor compares every handshake and done pulse against that list, and
// directed runs pin a few values to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_dram_dma_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 16;
    localparam int BYTES     = DATA_W / 8;

    logic        aclk;
    logic        areset;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] num_beats_i;
    logic        done_o;
    logic [15:0] err_cnt_o;
    logic [31:0] awaddr_o;
    logic [7:0]  awlen_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] wdata_o;
    logic        wlast_o;
    logic        wvalid_o;
    logic        wready_i;
    logic        bvalid_i;
    logic        bready_o;
    logic [1:0]  bresp_i;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [1:0]  rresp_i;

    dram_dma_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .num_beats_i(num_beats_i),
        .done_o     (done_o),
        .err_cnt_o  (err_cnt_o),
        .awaddr_o   (awaddr_o),
        .awlen_o    (awlen_o),
        .awvalid_o  (awvalid_o),
        .awready_i  (awready_i),
        .wdata_o    (wdata_o),
        .wlast_o    (wlast_o),
        .wvalid_o   (wvalid_o),
        .wready_i   (wready_i),
        .bvalid_i   (bvalid_i),
        .bready_o   (bready_o),
        .bresp_i    (bresp_i),
        .araddr_o   (araddr_o),
        .arlen_o    (arlen_o),
        .arvalid_o  (arvalid_o),
        .arready_i  (arready_i),
        .rdata_i    (rdata_i),
        .rlast_i    (rlast_i),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o),
        .rresp_i    (rresp_i)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Expected bus traffic of the current run and the observed log.
    burst_t      exp_aw[$];
    burst_t      exp_ar[$];
    beat_t       exp_w[$];
    burst_t      obs_aw[$];
    burst_t      obs_ar[$];
    logic [31:0] obs_w[$];
    logic [15:0] exp_err;
    bit          run_active = 1'b0;
    int          done_count = 0;

    // Fault injection and stall control.
    int corrupt_beat = -1;
    int rerr_beat    = -1;
    int berr_burst   = -1;
    int stall_pct    = 0;

    // Slave state.
    logic [31:0] mem [logic [31:0]];
    beat_t       rd_q[$];
    logic [31:0] w_addr = '0;
    int          w_left = 0;
    int          b_pending = 0;
    int          b_idx = 0;
    int          rd_idx = 0;
    bit          b_drop = 1'b0;
    bit          r_drop = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Expected bursts, beats and error count from the run's parameters.
    task automatic build_model(input logic [31:0] base, input int n);
        burst_t bt;
        beat_t  wt;
        int     len;
        int     errs;
        int     burst_no;
        exp_aw.delete();
        exp_ar.delete();
        exp_w.delete();
        obs_aw.delete();
        obs_ar.delete();
        obs_w.delete();
        b_idx    = 0;
        rd_idx   = 0;
        errs     = 0;
        burst_no = 0;
        for (int b = 0; b < n; b += BURST_LEN) begin
            len     = (n - b < BURST_LEN) ? (n - b) : BURST_LEN;
            bt.addr = base + 32'(b * BYTES);
            bt.len  = 8'(len - 1);
            exp_aw.push_back(bt);
            exp_ar.push_back(bt);
            for (int j = 0; j < len; j++) begin
                wt.data = base + 32'((b + j) * BYTES);
                wt.last = (j == len - 1);
                exp_w.push_back(wt);
            end
            if (burst_no == berr_burst) errs++;
            burst_no++;
        end
        for (int i = 0; i < n; i++) begin
            if (i == corrupt_beat || i == rerr_beat) errs++;
        end
        exp_err = (errs > 65535) ? 16'hFFFF : 16'(errs);
    endtask

    // Monitor + slave: checks on the falling edge, drives slave inputs just after the rising edge.
    initial begin : monitor
        bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit          p_awv, p_wv, p_arv, p_done;
        bit          p_hs_aw, p_hs_w, p_hs_ar;
        logic [31:0] p_awaddr, p_araddr, p_wdata;
        logic [7:0]  p_awlen, p_arlen;
        logic        p_wlast;
        burst_t      bt;
        beat_t       wt;
        int          outstanding;
        p_awv = 0; p_wv = 0; p_arv = 0; p_done = 0;
        p_hs_aw = 0; p_hs_w = 0; p_hs_ar = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_awlen = '0; p_arlen = '0; p_wlast = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                exp_aw.delete();
                exp_ar.delete();
                exp_w.delete();
                rd_q.delete();
                w_left = 0; b_pending = 0; b_drop = 0; r_drop = 0;
                b_idx = 0; rd_idx = 0;
                run_active = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_done = 0;
            end else begin
                hs_aw = awvalid_o && awready_i;
                hs_w  = wvalid_o && wready_i;
                hs_b  = bvalid_i && bready_o;
                hs_ar = arvalid_o && arready_i;
                hs_r  = rvalid_i && rready_o;

                outstanding = int'(awvalid_o) + int'(wvalid_o) + int'(bready_o) + int'(arvalid_o) + int'(rready_o);
                check("one_outstanding", 64'(outstanding <= 1), 64'd1);
                if (!run_active)
                    check("valid_while_idle", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'd0);

                if (p_awv && !p_hs_aw)
                    check("aw_stable", 64'(awvalid_o && awaddr_o == p_awaddr && awlen_o == p_awlen), 64'd1);
                if (p_wv && !p_hs_w)
                    check("w_stable", 64'(wvalid_o && wdata_o == p_wdata && wlast_o == p_wlast), 64'd1);
                if (p_arv && !p_hs_ar)
                    check("ar_stable", 64'(arvalid_o && araddr_o == p_araddr && arlen_o == p_arlen), 64'd1);

                if (hs_aw) begin
                    check("aw_expected", 64'(exp_aw.size() > 0), 64'd1);
                    if (exp_aw.size() > 0) begin
                        bt = exp_aw.pop_front();
                        check("aw_burst", {24'd0, awaddr_o, awlen_o}, {24'd0, bt.addr, bt.len});
                    end
                    bt.addr = awaddr_o;
                    bt.len  = awlen_o;
                    obs_aw.push_back(bt);
                    w_addr = awaddr_o;
                    w_left = int'(awlen_o) + 1;
                end
                if (hs_w) begin
                    check("w_expected", 64'(exp_w.size() > 0), 64'd1);
                    if (exp_w.size() > 0) begin
                        wt = exp_w.pop_front();
                        check("w_beat", {31'd0, wdata_o, wlast_o}, {31'd0, wt.data, wt.last});
                    end
                    obs_w.push_back(wdata_o);
                    mem[w_addr] = wdata_o;
                    w_addr = w_addr + 32'(BYTES);
                    w_left--;
                    if (w_left == 0) b_pending++;
                end
                if (hs_b) begin
                    b_pending--;
                    b_idx++;
                    b_drop = 1;
                end
                if (hs_ar) begin
                    check("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
                    if (exp_ar.size() > 0) begin
                        bt = exp_ar.pop_front();
                        check("ar_burst", {24'd0, araddr_o, arlen_o}, {24'd0, bt.addr, bt.len});
                    end
                    bt.addr = araddr_o;
                    bt.len  = arlen_o;
                    obs_ar.push_back(bt);
                    for (int j = 0; j <= int'(arlen_o); j++) begin
                        wt.data = araddr_o + 32'(j * BYTES);
                        wt.last = (j == int'(arlen_o));
                        rd_q.push_back(wt);
                    end
                end
                if (hs_r) begin
                    if (rd_q.size() > 0) void'(rd_q.pop_front());
                    rd_idx++;
                    r_drop = 1;
                end

                if (done_o) begin
                    check("done_single_cycle", 64'(p_done), 64'd0);
                    check("done_expected", 64'(run_active), 64'd1);
                    check("err_cnt_at_done", 64'(err_cnt_o), 64'(exp_err));
                    check("all_traffic_seen", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);
                    done_count++;
                    run_active = 0;
                end

                p_awv = awvalid_o; p_wv = wvalid_o; p_arv = arvalid_o; p_done = done_o;
                p_hs_aw = hs_aw; p_hs_w = hs_w; p_hs_ar = hs_ar;
                p_awaddr = awaddr_o; p_awlen = awlen_o;
                p_araddr = araddr_o; p_arlen = arlen_o;
                p_wdata = wdata_o; p_wlast = wlast_o;
            end

            @(posedge aclk);
            #1;
            if (areset) begin
                awready_i = 0; wready_i = 0; arready_i = 0;
                bvalid_i = 0; bresp_i = 0;
                rvalid_i = 0; rlast_i = 0; rresp_i = 0; rdata_i = '0;
            end else begin
                awready_i = ($urandom_range(99) >= stall_pct);
                wready_i  = ($urandom_range(99) >= stall_pct);
                arready_i = ($urandom_range(99) >= stall_pct);
                if (b_drop) begin
                    bvalid_i = 0; bresp_i = 0; b_drop = 0;
                end
                if (!bvalid_i && b_pending > 0 && $urandom_range(99) >= stall_pct) begin
                    bvalid_i = 1;
                    bresp_i  = (b_idx == berr_burst) ? 2'd2 : 2'd0;
                end
                if (r_drop) begin
                    rvalid_i = 0; rlast_i = 0; rresp_i = 0; r_drop = 0;
                end
                if (!rvalid_i && rd_q.size() > 0 && $urandom_range(99) >= stall_pct) begin
                    rvalid_i = 1;
                    rdata_i  = (mem.exists(rd_q[0].data) ? mem[rd_q[0].data] : 32'hDEAD_BEEF)
                               ^ ((rd_idx == corrupt_beat) ? 32'h0000_0100 : 32'h0);
                    rresp_i  = (rd_idx == rerr_beat) ? 2'd2 : 2'd0;
                    rlast_i  = rd_q[0].last;
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] n);
        @(posedge aclk);
        #1;
        start_i     = 1;
        base_addr_i = base;
        num_beats_i = n;
        @(posedge aclk);
        #1;
        start_i     = 0;
        base_addr_i = $urandom;
        num_beats_i = 16'($urandom);
    endtask

    task automatic do_run(input logic [31:0] base, input int n, input int stall,
                          input int cb, input int rb, input int bb, input bit busy_start);
        int d0;
        int cyc;
        stall_pct    = stall;
        corrupt_beat = cb;
        rerr_beat    = rb;
        berr_burst   = bb;
        build_model(base, n);
        run_active = 1;
        d0 = done_count;
        pulse_start(base, 16'(n));
        if (busy_start) begin
            repeat (3) @(posedge aclk);
            #1;
            start_i     = 1;
            base_addr_i = 32'h0000_F000;
            num_beats_i = 16'd5;
            @(posedge aclk);
            #1;
            start_i = 0;
        end
        cyc = 0;
        while (done_count == d0 && cyc < 20000) begin
            @(posedge aclk);
            cyc++;
        end
        check("done_reached", 64'(done_count != d0), 64'd1);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          n;
        int          cyc;
        int          d0;
        logic [31:0] base;
        areset = 1; start_i = 0; base_addr_i = '0; num_beats_i = '0;
        awready_i = 0; wready_i = 0; arready_i = 0;
        bvalid_i = 0; bresp_i = 0;
        rvalid_i = 0; rlast_i = 0; rresp_i = 0; rdata_i = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs", {46'd0, err_cnt_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_o}, 64'd0);
        areset = 0;
        repeat (2) @(posedge aclk);
        #1;

        // Single burst, zero-latency slave.
        do_run(32'h0000_1000, 16, 0, -1, -1, -1, 0);
        check("r041_aw_count", 64'(obs_aw.size()), 64'd1);
        check("r041_aw0", {24'd0, obs_aw[0].addr, obs_aw[0].len}, {24'd0, 32'h0000_1000, 8'd15});
        check("r041_w_first", 64'(obs_w[0]), 64'h1000);
        check("r041_w_last", 64'(obs_w[15]), 64'h103C);
        check("r041_ar0", {24'd0, obs_ar[0].addr, obs_ar[0].len}, {24'd0, 32'h0000_1000, 8'd15});
        check("r041_err", 64'(err_cnt_o), 64'd0);

        // Three bursts 16/16/8, with a start issued mid-run that must be ignored.
        do_run(32'h0000_1000, 40, 0, -1, -1, -1, 1);
        check("r042_aw_count", 64'(obs_aw.size()), 64'd3);
        check("r042_aw1", {24'd0, obs_aw[1].addr, obs_aw[1].len}, {24'd0, 32'h0000_1040, 8'd15});
        check("r042_aw2", {24'd0, obs_aw[2].addr, obs_aw[2].len}, {24'd0, 32'h0000_1080, 8'd7});
        check("r042_ar2", {24'd0, obs_ar[2].addr, obs_ar[2].len}, {24'd0, 32'h0000_1080, 8'd7});
        check("r042_err", 64'(err_cnt_o), 64'd0);

        // Corrupted beat 3 and rresp error on beat 5, without then with stalls.
        do_run(32'h0000_1000, 16, 0, 3, 5, -1, 0);
        check("r043_err", 64'(err_cnt_o), 64'd2);
        do_run(32'h0000_1000, 16, 40, 3, 5, -1, 0);
        check("r043_err_stalled", 64'(err_cnt_o), 64'd2);
        repeat (5) @(posedge aclk);
        #1;
        check("r043_err_held", 64'(err_cnt_o), 64'd2);
        do_run(32'h0000_2000, 16, 20, 4, 4, -1, 0);
        check("same_beat_counts_once", 64'(err_cnt_o), 64'd1);
        do_run(32'h0000_2000, 40, 20, -1, -1, 1, 0);
        check("bresp_error", 64'(err_cnt_o), 64'd1);

        // Empty run: done one cycle after start, no bus activity, count cleared.
        stall_pct = 0; corrupt_beat = -1; rerr_beat = -1; berr_burst = -1;
        build_model(32'h0000_2000, 0);
        run_active = 1;
        d0 = done_count;
        @(posedge aclk);
        #1;
        start_i = 1; base_addr_i = 32'h0000_2000; num_beats_i = 16'd0;
        @(negedge aclk);
        check("zero_done_before", 64'(done_o), 64'd0);
        @(posedge aclk);
        #1;
        start_i = 0;
        @(negedge aclk);
        check("zero_done_latency", 64'(done_o), 64'd1);
        check("zero_no_valid", 64'({awvalid_o, wvalid_o, arvalid_o}), 64'd0);
        check("zero_err_cleared", 64'(err_cnt_o), 64'd0);
        @(negedge aclk);
        check("zero_done_drop", 64'(done_o), 64'd0);
        check("zero_done_count", 64'(done_count - d0), 64'd1);

        // Reset in the middle of a write burst.
        stall_pct = 0;
        build_model(32'h0000_3000, 40);
        run_active = 1;
        pulse_start(32'h0000_3000, 16'd40);
        cyc = 0;
        @(negedge aclk);
        while (!wvalid_o && cyc < 200) begin
            @(negedge aclk);
            cyc++;
        end
        check("reach_wr_data", 64'(wvalid_o), 64'd1);
        #2;
        areset = 1;
        #1;
        check("reset_mid_burst", {46'd0, err_cnt_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_o}, 64'd0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 0;
        repeat (2) @(posedge aclk);
        #1;
        do_run(32'h0000_3000, 40, 30, -1, -1, -1, 0);
        check("after_reset_err", 64'(err_cnt_o), 64'd0);

        // Randomised runs.
        for (int k = 0; k < 15; k++) begin
            n    = int'($urandom_range(1, 70));
            base = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 6);
            do_run(base, n, int'($urandom_range(0, 60)),
                   ($urandom_range(1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
                   ($urandom_range(1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
                   ($urandom_range(1) == 1) ? int'($urandom_range(0, (n - 1) / BURST_LEN)) : -1,
                   (n > 20));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_dma_ctrl.md
DRAM_DMA_CTRL -- requirements
Module: dram_dma_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: HP0 AXI address width.
REQ-002 Parameter DATA_W, default 32: HP0 AXI data width, 32 or 64.
REQ-003 Parameter BURST_LEN, default 16: maximum beats per burst, power of 2, 1..256.
REQ-004 aclk  input  1  sole clock; all logic rising-edge.
REQ-005 areset  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  one-cycle request to begin a write-then-readback run.
REQ-007 base_addr_i  input  ADDR_W  first byte address; sampled on accepted start.
REQ-008 num_beats_i  input  16  total beats to write and read; sampled on accepted start.
REQ-009 done_o  output  1  one-cycle pulse when run completes.
REQ-010 err_cnt_o  output  16  mismatches and error responses in last run, saturating.
REQ-011 awaddr_o  output  ADDR_W  write burst address.
REQ-012 awlen_o  output  8  write burst beats minus one.
REQ-013 awvalid_o  output  1  write address valid.
REQ-014 awready_i  input  1  write address ready.
REQ-015 wdata_o  output  DATA_W  write beat data.
REQ-016 wlast_o  output  1  final beat of burst.
REQ-017 wvalid_o  output  1  write data valid.
REQ-018 wready_i  input  1  write data ready.
REQ-019 bvalid_i  input  1  write response valid.
REQ-020 bready_o  output  1  write response ready.
REQ-021 bresp_i  input  2  write response code.
REQ-022 araddr_o  output  ADDR_W  read burst address.
REQ-023 arlen_o  output  8  read burst beats minus one.
REQ-024 arvalid_o  output  1  read address valid.
REQ-025 arready_i  input  1  read address ready.
REQ-026 rdata_i  input  DATA_W  read beat data.
REQ-027 rlast_i  input  1  final read beat.
REQ-028 rvalid_i  input  1  read data valid.
REQ-029 rready_o  output  1  read data ready.
REQ-030 rresp_i  input  2  read response code.
REQ-031 Size = log2(DATA_W/8), burst = INCR, wstrb = all ones, id = 0: tied off by the instantiating top, not ports.

Function
REQ-032 States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE. Only one AXI transaction is outstanding at a time.
REQ-033 IDLE + start_i: latch inputs, clear err_cnt_o, go WR_ADDR; go to DONE if num_beats_i = 0. start_i outside IDLE is ignored.
REQ-034 Burst length = min(BURST_LEN, remaining beats). awlen_o/arlen_o = length-1. Burst address advances by length*DATA_W/8. base_addr_i must be aligned to BURST_LEN*DATA_W/8 (4KB rule; not checked).
REQ-035 Write path: WR_ADDR holds awvalid_o until awready_i. WR_DATA drives wvalid_o continuously. Beat i of the run carries wdata_o = byte address of that beat, zero-extended. wlast_o marks the burst's final beat. WR_RESP asserts bready_o. On bvalid_i: next write burst, or RD_ADDR at base when all beats are written.
REQ-036 Read path: RD_ADDR holds arvalid_o until arready_i. RD_DATA asserts rready_o. Each beat is compared to its address pattern. rlast_i ends the burst: next read burst, or DONE.
REQ-037 err_cnt_o increments by 1 per mismatching beat, per read beat with rresp_i != 0, and per bresp_i != 0. A beat with both a mismatch and an error response counts once. The count saturates at 0xFFFF and holds until the next accepted start.
REQ-038 DONE asserts done_o for exactly one cycle, then returns to IDLE. Minimum latency from start (num_beats 0) to done_o is 1 cycle.
REQ-039 valid outputs hold stable, with payload fixed, until handshake (AXI rule).

Reset
REQ-040 areset forces IDLE and sets all valid/ready outputs, done_o, err_cnt_o and counters to 0, immediately, including mid-burst. No AXI cleanup is performed.

Verification
REQ-041 base 0x1000, 16 beats, zero-latency slave: one write burst (awlen 15, data 0x1000..0x103C), one read burst, done_o pulse, err_cnt_o = 0.
REQ-042 40 beats, BURST_LEN 16: bursts of lengths 16, 16, 8 at 0x1000/0x1040/0x1080 for both write and read, err_cnt_o = 0.
REQ-043 Slave corrupts read beat 3 and returns rresp = 2 on beat 5: err_cnt_o = 2. Random ready stalls leave the result unchanged.
REQ-044 num_beats_i = 0: no AXI valid ever asserts; done_o 1 cycle after start_i. A start_i issued while busy is ignored.
REQ-045 areset asserted during WR_DATA: all valids low in the same cycle. A next run after release completes normally with err_cnt_o = 0.
